// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared declarations for the NPU output path.
//   piso_state_e : two-state serialiser FSM encoding (IDLE=0, SHIFT=1)
//   piso_nbytes  : number of BYTE_W beats in one NUM_CH*CH_W word
//   piso_cnt_w   : beat counter width, clog2(nbytes) with a floor of 1
// -----------------------------------------------------------------------------
package npu_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   function automatic int unsigned piso_nbytes(input int unsigned num_ch,
                                               input int unsigned ch_w,
                                               input int unsigned byte_w);
      return (num_ch * ch_w) / byte_w;
   endfunction

   // A single-beat word still needs a 1-bit counter so the vector is legal.
   function automatic int unsigned piso_cnt_w(input int unsigned nbytes);
      return (nbytes <= 1) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/piso_out_nch.sv
// -----------------------------------------------------------------------------
// piso_out_nch
// Captures NUM_CH packed MAC channels in one load and serialises them as
// BYTE_W-bit beats, MSB first (channel 0 occupies the top slice of MAC_IN).
// The first beat is presented straight from the shift register in the cycle
// after the load edge. A final-beat acceptance coinciding with a load request
// reloads without an idle bubble.
//
// Optional feature: define PISO_OUT_PARITY_EN to add D_PAR (XOR of D_OUT).
//
// Ports
//   CLKEXT        in   clock, rising edge
//   RST_GLO       in   asynchronous active-high reset
//   CLR_PISO_OUT  in   synchronous clear, overrides everything else
//   EN_PISO_OUT   in   load request
//   MAC_IN        in   NUM_CH*CH_W packed channels
//   SHIFT_OUT     in   consumer ready
//   D_OUT         out  current beat (0 while idle)
//   D_VALID       out  D_OUT holds a valid beat
//   BUSY          out  serialisation in progress
//   DONE          out  one-cycle pulse after the final beat is accepted
//   LOAD_ERR      out  one-cycle pulse when a load request is dropped
//   D_PAR         out  even parity of D_OUT (PISO_OUT_PARITY_EN only)
// -----------------------------------------------------------------------------
module piso_out_nch
   import npu_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CH_W   = 16,
   parameter int unsigned BYTE_W = 8
) (
   input  logic                     CLKEXT,
   input  logic                     RST_GLO,
   input  logic                     CLR_PISO_OUT,
   input  logic                     EN_PISO_OUT,
   input  logic [NUM_CH*CH_W-1:0]   MAC_IN,
   input  logic                     SHIFT_OUT,
   output logic [BYTE_W-1:0]        D_OUT,
   output logic                     D_VALID,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     LOAD_ERR
`ifdef PISO_OUT_PARITY_EN
   ,
   output logic                     D_PAR
`endif
);

   localparam int unsigned TOT_W  = NUM_CH * CH_W;
   localparam int unsigned NBYTES = piso_nbytes(NUM_CH, CH_W, BYTE_W);
   localparam int unsigned CNT_W  = piso_cnt_w(NBYTES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

   piso_state_e        state_q, state_d;
   logic [TOT_W-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               load_err_q, load_err_d;

   logic               accept;
   logic               last_accept;

   assign accept      = (state_q == SHIFT) && SHIFT_OUT;
   assign last_accept = accept && (cnt_q == LAST_CNT);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;

      if (CLR_PISO_OUT) begin
         // Abort: no DONE for the discarded word, pending pulses cleared.
         state_d = IDLE;
         sreg_d  = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (EN_PISO_OUT) begin
                  sreg_d  = MAC_IN;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end

            SHIFT: begin
               if (last_accept) begin
                  done_d = 1'b1;
                  if (EN_PISO_OUT) begin
                     // Back-to-back reload: next word's first beat follows
                     // immediately.
                     sreg_d  = MAC_IN;
                     cnt_d   = '0;
                     state_d = SHIFT;
                  end else begin
                     // All bits have been shifted out already; clearing
                     // explicitly keeps D_OUT at zero while idle.
                     sreg_d  = '0;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  if (accept) begin
                     sreg_d = sreg_q << BYTE_W;
                     cnt_d  = cnt_q + CNT_W'(1);
                  end
                  // Load while mid-word is dropped; contents keep going.
                  if (EN_PISO_OUT) begin
                     load_err_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = IDLE;
               sreg_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLKEXT or posedge RST_GLO) begin
      if (RST_GLO) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs, all taken directly from registers
   // ------------------------------------------------------------------
   assign D_OUT    = sreg_q[TOT_W-1 -: BYTE_W];
   assign D_VALID  = (state_q == SHIFT);
   assign BUSY     = (state_q == SHIFT);
   assign DONE     = done_q;
   assign LOAD_ERR = load_err_q;

`ifdef PISO_OUT_PARITY_EN
   // D_OUT is zero while idle, so parity is zero there as well.
   assign D_PAR = ^D_OUT;
`endif

endmodule

// File: tb/tb_piso_out_nch.sv
// -----------------------------------------------------------------------------
// tb_piso_out_nch
// Scoreboard bench for piso_out_nch. Instance A uses default parameters,
// instance B uses NUM_CH=4, CH_W=12, BYTE_W=4. Stimulus pushes the expected
// beats; per-instance monitors compare beats at acceptance and hold values
// while the consumer stalls. Define PISO_OUT_PARITY_EN to also check D_PAR.
// -----------------------------------------------------------------------------
module tb_piso_out_nch;

   logic clk;
   logic rst;

   // Instance A (defaults)
   logic        a_clr, a_en, a_so;
   logic [31:0] a_mac;
   logic [7:0]  a_dout;
   logic        a_valid, a_busy, a_done, a_le;

   // Instance B (4 x 12-bit, nibble beats)
   logic        b_clr, b_en, b_so;
   logic [47:0] b_mac;
   logic [3:0]  b_dout;
   logic        b_valid, b_busy, b_done, b_le;

`ifdef PISO_OUT_PARITY_EN
   logic a_par, b_par;
`endif

   logic [7:0] a_q[$];
   logic [3:0] b_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int a_done_cnt = 0, a_le_cnt = 0;
   int b_done_cnt = 0, b_le_cnt = 0;

   piso_out_nch u_dut_a (
      .CLKEXT       (clk),
      .RST_GLO      (rst),
      .CLR_PISO_OUT (a_clr),
      .EN_PISO_OUT  (a_en),
      .MAC_IN       (a_mac),
      .SHIFT_OUT    (a_so),
      .D_OUT        (a_dout),
      .D_VALID      (a_valid),
      .BUSY         (a_busy),
      .DONE         (a_done),
      .LOAD_ERR     (a_le)
`ifdef PISO_OUT_PARITY_EN
      ,
      .D_PAR        (a_par)
`endif
   );

   piso_out_nch #(
      .NUM_CH (4),
      .CH_W   (12),
      .BYTE_W (4)
   ) u_dut_b (
      .CLKEXT       (clk),
      .RST_GLO      (rst),
      .CLR_PISO_OUT (b_clr),
      .EN_PISO_OUT  (b_en),
      .MAC_IN       (b_mac),
      .SHIFT_OUT    (b_so),
      .D_OUT        (b_dout),
      .D_VALID      (b_valid),
      .BUSY         (b_busy),
      .DONE         (b_done),
      .LOAD_ERR     (b_le)
`ifdef PISO_OUT_PARITY_EN
      ,
      .D_PAR        (b_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input bit sel_b, input string name);
      int k = 0;
      while (((sel_b ? b_q.size() : a_q.size()) != 0) && (k < 100)) begin
         tick();
         k++;
      end
      if (k >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard not drained, got %0d beats left, expected 0", name,
                  sel_b ? b_q.size() : a_q.size());
      end
   endtask

   // ------------------------------------------------------------------
   // Monitors: sample on the falling edge, away from the active edge
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      logic [7:0] exp_a;
      if (a_valid) begin
         chk("a_busy_in_shift", a_busy, 1);
         if (a_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL a_unexpected_beat: got %0h, expected no beat", a_dout);
         end else if (a_so) begin
            exp_a = a_q.pop_front();
            chk("a_beat", a_dout, exp_a);
         end else begin
            chk("a_beat_hold", a_dout, a_q[0]);
         end
      end else begin
         chk("a_idle_dout", a_dout, 0);
         chk("a_idle_busy", a_busy, 0);
      end
`ifdef PISO_OUT_PARITY_EN
      chk("a_parity", a_par, ^a_dout);
`endif
      if (a_done) a_done_cnt++;
      if (a_le)   a_le_cnt++;
   end

   always @(negedge clk) begin
      logic [3:0] exp_b;
      if (b_valid) begin
         chk("b_busy_in_shift", b_busy, 1);
         if (b_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL b_unexpected_beat: got %0h, expected no beat", b_dout);
         end else if (b_so) begin
            exp_b = b_q.pop_front();
            chk("b_beat", b_dout, exp_b);
         end else begin
            chk("b_beat_hold", b_dout, b_q[0]);
         end
      end else begin
         chk("b_idle_dout", b_dout, 0);
      end
`ifdef PISO_OUT_PARITY_EN
      chk("b_parity", b_par, ^b_dout);
`endif
      if (b_done) b_done_cnt++;
      if (b_le)   b_le_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      rst   = 1'b0;
      a_clr = 1'b0; a_en = 1'b0; a_so = 1'b0; a_mac = '0;
      b_clr = 1'b0; b_en = 1'b0; b_so = 1'b0; b_mac = '0;
      #2 rst = 1'b1;
      tick();
      tick();
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_dout",  a_dout,  0);
      chk("rst_a_busy",  a_busy,  0);
      chk("rst_a_done",  a_done,  0);
      chk("rst_a_le",    a_le,    0);
      chk("rst_b_valid", b_valid, 0);
      rst = 1'b0;
      tick();

      // Continuous ready: AA,AA,55,55 then DONE
      a_mac = {16'hAAAA, 16'h5555};
      a_q.push_back(8'hAA); a_q.push_back(8'hAA);
      a_q.push_back(8'h55); a_q.push_back(8'h55);
      a_en = 1'b1; a_so = 1'b1;
      tick();
      a_en = 1'b0;
      chk("t1_first_beat_valid", a_valid, 1);
      chk("t1_first_beat", a_dout, 8'hAA);
      wait_empty(1'b0, "t1_drain");
      chk("t1_done", a_done, 1);
      chk("t1_idle_after", a_valid, 0);
      tick();
      chk("t1_done_single", a_done, 0);

      // Stalling consumer: 12,34,AB,CD with ready toggling 1,0,1,0
      a_mac = {16'h1234, 16'hABCD};
      a_q.push_back(8'h12); a_q.push_back(8'h34);
      a_q.push_back(8'hAB); a_q.push_back(8'hCD);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         a_so = (i % 2 == 0);
         tick();
      end
      chk("t2_done", a_done, 1);
      chk("t2_drained", a_q.size(), 0);
      a_so = 1'b1;
      tick();
      chk("t2_done_single", a_done, 0);

      // Dropped load mid-word, then back-to-back reload on final beat
      a_mac = {16'hFFFF, 16'h0000};
      a_q.push_back(8'hFF); a_q.push_back(8'hFF);
      a_q.push_back(8'h00); a_q.push_back(8'h00);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      tick();
      a_en = 1'b1;
      a_mac = {16'h0102, 16'h0304};
      tick();
      chk("t3_load_err", a_le, 1);
      chk("t3_contents_kept", a_dout, 8'h00);
      chk("t3_still_busy", a_busy, 1);
      a_en = 1'b0;
      tick();
      chk("t3_load_err_pulse", a_le, 0);
      a_en = 1'b1;
      a_q.push_back(8'h01); a_q.push_back(8'h02);
      a_q.push_back(8'h03); a_q.push_back(8'h04);
      tick();
      a_en = 1'b0;
      chk("t3_reload_done", a_done, 1);
      chk("t3_no_bubble_valid", a_valid, 1);
      chk("t3_no_bubble_beat", a_dout, 8'h01);
      wait_empty(1'b0, "t3_drain");
      chk("t3_done2", a_done, 1);
      tick();

      // Synchronous clear after beat 1
      a_mac = {16'h1234, 16'hABCD};
      a_q.push_back(8'h12); a_q.push_back(8'h34);
      a_q.push_back(8'hAB); a_q.push_back(8'hCD);
      a_en = 1'b1; a_so = 1'b1;
      tick();
      a_en = 1'b0;
      tick();
      tick();
      a_so = 1'b0;
      a_clr = 1'b1;
      tick();
      a_q.delete();
      a_clr = 1'b0;
      chk("t4_clr_valid", a_valid, 0);
      chk("t4_clr_dout",  a_dout,  0);
      chk("t4_clr_done",  a_done,  0);
      tick();
      chk("t4_no_done", a_done, 0);
      a_mac = {16'hC0DE, 16'hBEEF};
      a_q.push_back(8'hC0); a_q.push_back(8'hDE);
      a_q.push_back(8'hBE); a_q.push_back(8'hEF);
      a_en = 1'b1; a_so = 1'b1;
      tick();
      a_en = 1'b0;
      wait_empty(1'b0, "t4_drain");
      chk("t4_done", a_done, 1);
      tick();

      // Asynchronous reset between edges mid-word
      a_mac = {16'h5A5A, 16'h0F0F};
      a_q.push_back(8'h5A); a_q.push_back(8'h5A);
      a_q.push_back(8'h0F); a_q.push_back(8'h0F);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      tick();
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_valid", a_valid, 0);
      chk("t5_rst_dout",  a_dout,  0);
      chk("t5_rst_busy",  a_busy,  0);
      a_q.delete();
      rst = 1'b0;
      a_mac = {16'h9876, 16'h5432};
      a_q.push_back(8'h98); a_q.push_back(8'h76);
      a_q.push_back(8'h54); a_q.push_back(8'h32);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      chk("t5_fresh_load", a_valid, 1);
      chk("t5_fresh_beat", a_dout, 8'h98);
      wait_empty(1'b0, "t5_drain");
      chk("t5_done", a_done, 1);
      tick();

      // Instance B: 12 nibbles 1..C
      b_mac = 48'h123456789ABC;
      for (int i = 1; i <= 12; i++) b_q.push_back(4'(i));
      b_en = 1'b1; b_so = 1'b1;
      tick();
      b_en = 1'b0;
      chk("t6_first_nibble", b_dout, 4'h1);
      wait_empty(1'b1, "t6_drain");
      chk("t6_done", b_done, 1);
      tick();
      tick();

      chk("a_done_count", a_done_cnt, 6);
      chk("a_load_err_count", a_le_cnt, 1);
      chk("b_done_count", b_done_cnt, 1);
      chk("b_load_err_count", b_le_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_out_nch.md
PISO_OUT_NCH -- requirements
Module: piso_out_nch

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2, giving the number of MAC channels captured per load.
REQ-002 The module SHALL have parameter CH_W, default 16, giving the width of each channel in bits.
REQ-003 The module SHALL have parameter BYTE_W, default 8, giving the output beat width in bits; NUM_CH*CH_W SHALL be an integer multiple of BYTE_W, and NBYTES = NUM_CH*CH_W/BYTE_W.
REQ-004 The module SHALL have port CLKEXT, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port RST_GLO, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port CLR_PISO_OUT, input, 1 bit: synchronous clear.
REQ-007 The module SHALL have port EN_PISO_OUT, input, 1 bit: load request.
REQ-008 The module SHALL have port MAC_IN, input, NUM_CH*CH_W bits: packed channels, channel 0 in the most-significant slice.
REQ-009 The module SHALL have port SHIFT_OUT, input, 1 bit: consumer ready.
REQ-010 The module SHALL have port D_OUT, output, BYTE_W bits: current output beat.
REQ-011 The module SHALL have port D_VALID, output, 1 bit: D_OUT holds a valid beat.
REQ-012 The module SHALL have port BUSY, output, 1 bit: a serialisation is in progress.
REQ-013 The module SHALL have port DONE, output, 1 bit: one-cycle pulse after the final beat is accepted.
REQ-014 The module SHALL have port LOAD_ERR, output, 1 bit: one-cycle pulse when a load request is dropped.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SHIFT; BUSY and D_VALID SHALL both equal (state==SHIFT).
REQ-016 In IDLE, EN_PISO_OUT=1 SHALL capture MAC_IN into the shift register, clear the beat counter and enter SHIFT at that edge.
REQ-017 D_OUT SHALL be driven directly from registers as the top BYTE_W bits of the shift register, so the first beat is valid in the cycle following the load edge (zero-latency first beat).
REQ-018 A beat SHALL be accepted at an edge where D_VALID=1 and SHIFT_OUT=1; on acceptance the register SHALL shift left by BYTE_W with zero fill and the counter SHALL increment.
REQ-019 With SHIFT_OUT=0, D_OUT, the counter and the state SHALL hold indefinitely.
REQ-020 Beats SHALL be emitted MSB-first, so channel 0 bits [CH_W-1:CH_W-BYTE_W] form the first beat.
REQ-021 Acceptance of beat NBYTES-1 SHALL return the FSM to IDLE and pulse DONE in the following cycle.
REQ-022 If EN_PISO_OUT=1 at the edge accepting the final beat, the module SHALL load the new word and remain in SHIFT with no idle bubble; DONE SHALL still pulse.
REQ-023 EN_PISO_OUT=1 in SHIFT at any edge other than the final acceptance SHALL be ignored, with a LOAD_ERR pulse the following cycle and the shift contents unchanged.
REQ-024 CLR_PISO_OUT=1 SHALL override all other inputs: shift register, counter, DONE and LOAD_ERR set to 0, state set to IDLE, and no DONE pulse for the aborted word.
REQ-025 In IDLE, D_OUT SHALL be 0.

Reset
REQ-026 RST_GLO=1 SHALL immediately force state IDLE, shift register 0, counter 0, D_OUT=0, D_VALID=0, BUSY=0, DONE=0 and LOAD_ERR=0, independent of CLKEXT.
REQ-027 A reset asserted mid-word SHALL discard the word; after deassertion the module SHALL accept a fresh load on the first clock edge.

Configuration
REQ-028 With macro PISO_OUT_PARITY_EN defined, the module SHALL add output D_PAR (1 bit), the even parity (XOR) of D_OUT, which is 0 in IDLE.
REQ-029 Without PISO_OUT_PARITY_EN, the D_PAR port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The state encoding (IDLE=0, SHIFT=1) and the NBYTES/counter-width helper function SHALL reside in the shared package npu_pkg.
REQ-031 The block SHALL be implemented as a single module with no sub-module; the counter width SHALL be clog2(NBYTES), with a minimum of 1.

Verification
REQ-032 Defaults, MAC_IN={16'hAAAA,16'h5555}, load, SHIFT_OUT=1 held -> D_OUT sequence AA,AA,55,55 on consecutive cycles, then a single DONE pulse.
REQ-033 Defaults, MAC_IN={16'h1234,16'hABCD}, SHIFT_OUT toggled 1,0,1,0,... -> beats 12,34,AB,CD, each beat held while SHIFT_OUT=0, then DONE.
REQ-034 Load {16'hFFFF,16'h0000}, with EN_PISO_OUT reasserted at beat 1 -> LOAD_ERR pulse and output unchanged; EN_PISO_OUT reasserted at the final-beat edge with {16'h0102,16'h0304} -> 01 appears in the next cycle with no bubble.
REQ-035 CLR_PISO_OUT pulsed after beat 1, and separately RST_GLO pulsed between clock edges mid-word -> D_VALID=0 and D_OUT=00 immediately after each, no DONE, and the next load serialises correctly.
REQ-036 NUM_CH=4, CH_W=12, BYTE_W=4, MAC_IN=48'h123456789ABC -> 12 nibbles 1,2,...,C, then DONE; with PISO_OUT_PARITY_EN, D_PAR matches the XOR of each nibble.
